// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM SPI SRAM access blocks: opcodes, frame size
// and the write-drainer state encoding.
package vram_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  localparam int FRAME_BITS              = 48;
  localparam int DESELECT_CYCLES_DEFAULT = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_GNT = 3'd1,
    SELECT   = 3'd2,
    SHIFT    = 3'd3,
    DESELECT = 3'd4
  } state_t;

endpackage

// File: rtl/vram_spi_shift_out.sv
// 48-bit SPI mode-0 serializer: a load/shift register, a two-phase sclk toggle
// and a bit counter. The top-level state machine decides when to load and shift.
module vram_spi_shift_out
  import vram_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] load_data,
  input  logic                  shift_en,
  output logic                  ram_sclk,
  output logic                  ram_mosi,
  output logic                  last_bit
);

  // Bit 47 goes straight to ram_mosi on load, so only the remaining 47 bits are kept.
  logic [FRAME_BITS-2:0] sr;
  logic                  phase;
  logic [5:0]            bit_cnt;

  // Phase H raises sclk; phase L drops it and presents the next bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr       <= '0;
      phase    <= 1'b0;
      bit_cnt  <= 6'd0;
      ram_sclk <= 1'b0;
      ram_mosi <= 1'b0;
      last_bit <= 1'b0;
    end else if (load) begin
      sr       <= load_data[FRAME_BITS-2:0];
      phase    <= 1'b0;
      bit_cnt  <= 6'd0;
      ram_sclk <= 1'b0;
      ram_mosi <= load_data[FRAME_BITS-1];
      last_bit <= 1'b0;
    end else if (shift_en) begin
      if (!phase) begin
        ram_sclk <= 1'b1;
        phase    <= 1'b1;
      end else begin
        ram_sclk <= 1'b0;
        phase    <= 1'b0;
        if (bit_cnt == 6'd47) begin
          // Final falling edge: nothing left to present, park the data line low.
          ram_mosi <= 1'b0;
          last_bit <= 1'b1;
        end else begin
          ram_mosi <= sr[FRAME_BITS-2];
          sr       <= {sr[FRAME_BITS-3:0], 1'b0};
          bit_cnt  <= bit_cnt + 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/vram_write_drainer.sv
// Drains the VRAM write FIFO: each entry becomes one SPI SRAM write frame
// (opcode, 24-bit byte address, 16-bit word) under a per-word bus grant.
module vram_write_drainer
  import vram_pkg::*;
#(
  parameter int         DATA_WIDTH      = 16,
  parameter int         ADDRESS_WIDTH   = 16,
  parameter logic [7:0] CMD_WRITE       = 8'h02,
  parameter int         DESELECT_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fifo_empty,
  input  logic [ADDRESS_WIDTH-1:0] fifo_read_address,
  input  logic [DATA_WIDTH-1:0]    fifo_read_data,
  output logic                     fifo_read_request,
  output logic                     bus_req,
  input  logic                     bus_gnt,
  output logic                     ram_cs_n,
  output logic                     ram_sclk,
  output logic                     ram_mosi,
  output logic                     busy,
  output logic                     write_done
);

  state_t                state;
  state_t                state_next;
  logic [3:0]            desel_cnt;
  logic                  load;
  logic                  shift_en;
  logic                  last_bit;
  logic                  cs_n_next;
  logic                  bus_req_next;
  logic                  write_done_next;
  logic [FRAME_BITS-1:0] frame;

  // Word address becomes a byte address, zero padded on the MSB side to 24 bits.
  assign frame = {CMD_WRITE, 24'({fifo_read_address, 1'b0}), fifo_read_data};

  vram_spi_shift_out u_shift (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (frame),
    .shift_en  (shift_en),
    .ram_sclk  (ram_sclk),
    .ram_mosi  (ram_mosi),
    .last_bit  (last_bit)
  );

  // Next-state and next-output logic; registered outputs change on the transition edge.
  always_comb begin
    state_next        = state;
    load              = 1'b0;
    shift_en          = 1'b0;
    fifo_read_request = 1'b0;
    cs_n_next         = ram_cs_n;
    bus_req_next      = bus_req;
    write_done_next   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          bus_req_next = 1'b1;
          state_next   = WAIT_GNT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT_GNT: begin
        if (bus_gnt && !fifo_empty) begin
          fifo_read_request = 1'b1;
          load              = 1'b1;
          cs_n_next         = 1'b0;
          state_next        = SELECT;
        end else begin
          state_next = WAIT_GNT;
        end
      end
      SELECT: begin
        shift_en   = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        if (last_bit) begin
          cs_n_next       = 1'b1;
          bus_req_next    = 1'b0;
          write_done_next = 1'b1;
          state_next      = DESELECT;
        end else begin
          shift_en = 1'b1;
        end
      end
      DESELECT: begin
        if (desel_cnt == 4'(DESELECT_CYCLES - 1)) begin
          state_next = IDLE;
        end else begin
          state_next = DESELECT;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered output updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ram_cs_n   <= 1'b1;
      bus_req    <= 1'b0;
      busy       <= 1'b0;
      write_done <= 1'b0;
      desel_cnt  <= 4'd0;
    end else begin
      state      <= state_next;
      ram_cs_n   <= cs_n_next;
      bus_req    <= bus_req_next;
      busy       <= (state_next != IDLE);
      write_done <= write_done_next;
      desel_cnt  <= (state == DESELECT) ? desel_cnt + 4'd1 : 4'd0;
    end
  end

endmodule

// File: tb/tb_vram_write_drainer.sv
// Bench for vram_write_drainer: FIFO and arbiter models, an SPI frame monitor,
// table vectors, corner sequences and randomized traffic against an arithmetic model.
module tb_vram_write_drainer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        fifo_empty;
  logic [15:0] fifo_read_address;
  logic [15:0] fifo_read_data;
  logic        fifo_read_request;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic        ram_cs_n, ram_sclk, ram_mosi, busy, write_done;

  typedef struct packed { logic [15:0] addr; logic [15:0] data; } entry_t;
  entry_t     fifo_mem [64];
  logic [5:0] wr_ptr = 6'd0;
  logic [5:0] rd_ptr = 6'd0;
  assign fifo_empty        = (wr_ptr == rd_ptr);
  assign fifo_read_address = fifo_mem[rd_ptr].addr;
  assign fifo_read_data    = fifo_mem[rd_ptr].data;

  vram_write_drainer u_dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty),
    .fifo_read_address(fifo_read_address), .fifo_read_data(fifo_read_data),
    .fifo_read_request(fifo_read_request), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .ram_cs_n(ram_cs_n), .ram_sclk(ram_sclk), .ram_mosi(ram_mosi),
    .busy(busy), .write_done(write_done)
  );

  // Second build with a longer deselect gap; its arbiter grants whenever requested.
  logic fifo_empty5, fifo_read_request5, bus_req5, ram_cs_n5, ram_sclk5, ram_mosi5, busy5, write_done5;
  int   entries5 = 0;
  assign fifo_empty5 = (entries5 == 0);

  vram_write_drainer #(.DESELECT_CYCLES(5)) u_dut5 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty5),
    .fifo_read_address(16'h0042), .fifo_read_data(16'h9999),
    .fifo_read_request(fifo_read_request5), .bus_req(bus_req5), .bus_gnt(bus_req5),
    .ram_cs_n(ram_cs_n5), .ram_sclk(ram_sclk5), .ram_mosi(ram_mosi5),
    .busy(busy5), .write_done(write_done5)
  );

  typedef struct packed {
    logic [47:0] bits;
    logic [31:0] nbits;
    logic [31:0] low;
    logic        wd;
  } frame_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          gnt_dly;
    logic [47:0] frame;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  frame_t      done_q[$];
  int          gap_q[$];
  int          gap5_q[$];
  int          cur_nbits = 0;
  int          wd_pulses = 0, frames_seen = 0, underruns = 0, pop_cnt = 0, wd5 = 0;
  int          gnt_delay = 0, arb_cnt = 0;
  bit          rand_gnt = 1'b0;
  logic [47:0] m_bits;
  int          m_nb, m_low, m_gap, m5_gap;
  logic        m_prev_cs, m_prev_sclk, m_have_end, m5_prev, m5_have;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    fifo_mem[wr_ptr] = '{addr: a, data: d};
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic expect_frame(input string name, input logic [47:0] exp);
    int     t;
    frame_t f;
    t = 0;
    while (done_q.size() == 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (done_q.size() == 0) begin
      check({name, "_timeout"}, 64'd0, 64'd1);
    end else begin
      f = done_q.pop_front();
      check({name, "_bits"}, 64'(f.bits), 64'(exp));
      check({name, "_nsclk"}, 64'(f.nbits), 64'd48);
      check({name, "_cs_low"}, 64'(f.low), 64'd97);
      check({name, "_done"}, 64'(f.wd), 64'd1);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 400) begin
      @(negedge clk);
      t++;
    end
  endtask

  vec_t        vecs [6];
  logic [47:0] model_q[$];
  logic [15:0] ra, rd;
  int          cnt, viol, p0;

  initial begin
    vecs[0] = '{16'h1234, 16'hABCD, 0,  48'h02_002468_ABCD};
    vecs[1] = '{16'h0000, 16'hFFFF, 0,  48'h02_000000_FFFF};
    vecs[2] = '{16'h7FFF, 16'h0001, 0,  48'h02_00FFFE_0001};
    vecs[3] = '{16'h4000, 16'h5555, 0,  48'h02_008000_5555};
    vecs[4] = '{16'h0BEE, 16'h3C3C, 20, 48'h02_0017DC_3C3C};
    vecs[5] = '{16'hFFFF, 16'h8001, 0,  48'h02_01FFFE_8001};

    fork
      // Arbiter: grant gnt_delay cycles after the request, drop with the request.
      forever begin
        @(posedge clk); #1;
        if (!bus_req) begin
          arb_cnt = 0;
          bus_gnt = 1'b0;
          if (rand_gnt) gnt_delay = $urandom_range(0, 5);
        end else if (arb_cnt >= gnt_delay) begin
          bus_gnt = 1'b1;
        end else begin
          arb_cnt++;
        end
      end
      // FIFO pop side.
      forever begin
        @(negedge clk);
        if (fifo_read_request) begin
          pop_cnt++;
          if (fifo_empty) underruns++;
          @(posedge clk); #1;
          if (!fifo_empty) rd_ptr = rd_ptr + 6'd1;
        end
      end
      forever begin
        @(negedge clk);
        if (fifo_read_request5) begin
          @(posedge clk); #1;
          if (entries5 > 0) entries5--;
        end
      end
      // SPI monitor: collects bits on sclk rises inside each cs_n low window.
      forever begin
        @(negedge clk);
        if (write_done) wd_pulses++;
        if (reset) begin
          m_nb = 0; m_low = 0; m_prev_cs = 1'b1; m_prev_sclk = 1'b0; m_have_end = 1'b0; cur_nbits = 0;
        end else begin
          if (!ram_cs_n) begin
            if (m_prev_cs) begin
              if (m_have_end) gap_q.push_back(m_gap);
              m_nb = 0; m_low = 0; m_bits = 48'd0;
            end
            m_low++;
            if (ram_sclk && !m_prev_sclk) begin
              m_bits = {m_bits[46:0], ram_mosi};
              m_nb++;
            end
            cur_nbits = m_nb;
          end else begin
            if (!m_prev_cs) begin
              done_q.push_back('{bits: m_bits, nbits: 32'(m_nb), low: 32'(m_low), wd: write_done});
              frames_seen++;
              m_have_end = 1'b1;
              m_gap = 0;
            end
            m_gap++;
          end
          m_prev_cs   = ram_cs_n;
          m_prev_sclk = ram_sclk;
        end
      end
      forever begin
        @(negedge clk);
        if (write_done5) wd5++;
        if (reset) begin
          m5_prev = 1'b1; m5_have = 1'b0; m5_gap = 0;
        end else begin
          if (ram_cs_n5) begin
            if (!m5_prev) begin m5_have = 1'b1; m5_gap = 0; end
            m5_gap++;
          end else if (m5_prev && m5_have) begin
            gap5_q.push_back(m5_gap);
          end
          m5_prev = ram_cs_n5;
        end
      end
    join_none

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", 64'(ram_cs_n), 64'd1);
    check("rst_sclk", 64'(ram_sclk), 64'd0);
    check("rst_mosi", 64'(ram_mosi), 64'd0);
    check("rst_bus_req", 64'(bus_req), 64'd0);
    check("rst_pop", 64'(fifo_read_request), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(write_done), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Empty FIFO: nothing moves.
    viol = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus_req || fifo_read_request || !ram_cs_n || busy || ram_sclk) viol++;
      if (busy5 || ram_sclk5 || ram_mosi5 || !ram_cs_n5) viol++;
    end
    check("idle_quiet", 64'(viol), 64'd0);

    // Single write with the grant immediately available.
    p0 = pop_cnt;
    push(vecs[0].addr, vecs[0].data);
    expect_frame("single", vecs[0].frame);
    wait_idle();
    check("single_pops", 64'(pop_cnt - p0), 64'd1);

    // Three queued entries drain back to back.
    for (int i = 1; i <= 3; i++) push(vecs[i].addr, vecs[i].data);
    for (int i = 1; i <= 3; i++) begin
      expect_frame($sformatf("queued%0d", i), vecs[i].frame);
      if (i == 1) gap_q.delete();
    end
    wait_idle();
    check("queued_gaps", 64'(gap_q.size()), 64'd2);
    for (int i = 0; i < 2 && i < gap_q.size(); i++) check($sformatf("queued_gap%0d", i), 64'(gap_q[i]), 64'd4);
    check("queued_empty", 64'(fifo_empty), 64'd1);
    check("queued_underrun", 64'(underruns), 64'd0);

    // Grant withheld: request stays up with no pop until the grant arrives.
    gnt_delay = vecs[4].gnt_dly;
    push(vecs[4].addr, vecs[4].data);
    cnt = 0;
    @(negedge clk);
    while (!bus_req && cnt < 10) begin @(negedge clk); cnt++; end
    cnt = 0;
    while (bus_req && !fifo_read_request && cnt < 60) begin @(negedge clk); cnt++; end
    check("gnt_wait_cycles", 64'(cnt), 64'(vecs[4].gnt_dly));
    check("gnt_pop", 64'(fifo_read_request), 64'd1);
    check("gnt_cs_at_pop", 64'(ram_cs_n), 64'd1);
    @(negedge clk);
    check("gnt_cs_next", 64'(ram_cs_n), 64'd0);
    expect_frame("delayed", vecs[4].frame);
    gnt_delay = 0;
    wait_idle();

    // Reset in the middle of the shift phase, then a clean frame.
    push(16'h2222, 16'h1111);
    cnt = 0;
    while (cur_nbits != 20 && cnt < 300) begin @(negedge clk); cnt++; end
    check("abort_reached_bit20", 64'(cur_nbits), 64'd20);
    @(posedge clk); #1;
    reset  = 1'b1;
    rd_ptr = wr_ptr;
    @(posedge clk);
    @(negedge clk);
    check("abort_cs_n", 64'(ram_cs_n), 64'd1);
    check("abort_sclk", 64'(ram_sclk), 64'd0);
    check("abort_bus_req", 64'(bus_req), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    done_q.delete();
    push(vecs[5].addr, vecs[5].data);
    expect_frame("after_reset", vecs[5].frame);
    wait_idle();

    // Random traffic with random grant latency.
    rand_gnt = 1'b1;
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 120)) @(posedge clk);
      ra = 16'($urandom);
      rd = 16'($urandom);
      push(ra, rd);
      model_q.push_back((48'h02 << 40) | (48'(ra) << 17) | 48'(rd));
    end
    for (int i = 0; i < 12; i++) expect_frame($sformatf("rand%0d", i), model_q[i]);
    wait_idle();
    rand_gnt  = 1'b0;
    gnt_delay = 0;

    // Five-cycle deselect build: gap between its two frames.
    @(posedge clk); #1 entries5 = 2;
    cnt = 0;
    while (gap5_q.size() == 0 && cnt < 600) begin @(negedge clk); cnt++; end
    if (gap5_q.size() == 0) check("desel5_timeout", 64'd0, 64'd1);
    else check("desel5_gap", 64'(gap5_q[0]), 64'd7);
    repeat (220) @(negedge clk);
    check("desel5_done_pulses", 64'(wd5), 64'd2);

    check("done_pulses", 64'(wd_pulses), 64'(frames_seen));
    check("final_underrun", 64'(underruns), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
